// File: rtl/perf_params.sv
// Shared register offsets, CTRL/STATUS bit positions and the counter FSM
// state type for the performance-counter peripheral.
package perf_params;

  localparam int unsigned CTRL_OFF   = 0;
  localparam int unsigned STATUS_OFF = 1;
  localparam int unsigned CYC_LO_OFF = 2;
  localparam int unsigned CYC_HI_OFF = 3;
  localparam int unsigned INS_LO_OFF = 4;
  localparam int unsigned INS_HI_OFF = 5;
  localparam int unsigned CMP_OFF    = 6;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CLR    = 1;
  localparam int unsigned CTRL_FRZ    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned ST_RUN     = 0;
  localparam int unsigned ST_HALT    = 1;
  localparam int unsigned ST_CYC_OVF = 2;
  localparam int unsigned ST_INS_OVF = 3;
  localparam int unsigned ST_CMP_HIT = 4;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} perf_state_t;

endpackage

// File: rtl/perf_counter_mmio_if.sv
// Register-window bus between the CPU data path and the counter peripheral.
interface perf_counter_mmio_if #(
  parameter int unsigned ADDR_W = 3
) ();
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_valid;

  modport master (output addr, wr_en, rd_en, wdata, input rdata, rdata_valid);
  modport slave  (input addr, wr_en, rd_en, wdata, output rdata, rdata_valid);
endinterface

// File: rtl/perf_counter64.sv
// Free-running counter with synchronous clear; wrap_pulse marks the
// all-ones to zero transition.
module perf_counter64 #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             cycle_count_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap_pulse
);

  logic [CNT_W-1:0] count_d, count_q;

  // Clear takes priority so a same-cycle increment never reports a wrap.
  always_comb begin
    count_d    = count_q;
    wrap_pulse = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d    = count_q + CNT_W'(1);
      wrap_pulse = &count_q;
    end
  end

  always_ff @(posedge clk or posedge cycle_count_rst) begin
    if (cycle_count_rst) count_q <= '0;
    else                 count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/perf_counter_mmio.sv
// Memory-mapped cycle/instruction counter block with halt freeze, atomic
// 64-bit reads through LO-latched shadows, and a cycle-compare interrupt.
module perf_counter_mmio
  import perf_params::*;
#(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                clk,
  input  logic                cycle_count_rst,
  input  logic                cnt_start,
  input  logic                instr_retire,
  input  logic                hlt,
  perf_counter_mmio_if.slave  bus,
  output logic                irq
);

  perf_state_t state_d, state_q;
  logic en_d, en_q, frz_d, frz_q, irq_en_d, irq_en_q;
  logic cyc_ovf_d, cyc_ovf_q, ins_ovf_d, ins_ovf_q, cmp_hit_d, cmp_hit_q;
  logic hlt_d, hlt_q;
  logic [31:0] cmp_d, cmp_q;
  logic [CNT_W-33:0] cyc_shadow_d, cyc_shadow_q, ins_shadow_d, ins_shadow_q;
  logic [31:0] rdata_d, rdata_q;
  logic        rdata_valid_d, rdata_valid_q;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       addr_w;
  logic [CNT_W-1:0]  cyc_cnt, ins_cnt;
  logic              cyc_inc, ins_inc, cyc_wrap, ins_wrap, clr;
  logic              wr_ctrl, wr_status, cmp_set;

  assign addr   = bus.addr;
  assign addr_w = 32'(addr);

  assign cyc_inc = (state_q == RUN);
  assign ins_inc = (state_q == RUN) && instr_retire;

  perf_counter64 #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk             (clk),
    .cycle_count_rst (cycle_count_rst),
    .inc             (cyc_inc),
    .clr             (clr),
    .count           (cyc_cnt),
    .wrap_pulse      (cyc_wrap)
  );

  perf_counter64 #(.CNT_W(CNT_W)) u_ins_cnt (
    .clk             (clk),
    .cycle_count_rst (cycle_count_rst),
    .inc             (ins_inc),
    .clr             (clr),
    .count           (ins_cnt),
    .wrap_pulse      (ins_wrap)
  );

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    frz_d         = frz_q;
    irq_en_d      = irq_en_q;
    cmp_d         = cmp_q;
    hlt_d         = hlt;
    cyc_shadow_d  = cyc_shadow_q;
    ins_shadow_d  = ins_shadow_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    clr           = 1'b0;

    wr_ctrl   = bus.wr_en && (addr_w == CTRL_OFF);
    wr_status = bus.wr_en && (addr_w == STATUS_OFF);
    cmp_set   = (state_q == RUN) && irq_en_q && (cyc_cnt[31:0] == cmp_q);

    if (wr_ctrl) begin
      en_d     = bus.wdata[CTRL_EN];
      frz_d    = bus.wdata[CTRL_FRZ];
      irq_en_d = bus.wdata[CTRL_IRQ_EN];
      clr      = bus.wdata[CTRL_CLR];
    end
    if (bus.wr_en && (addr_w == CMP_OFF)) cmp_d = bus.wdata;

    // Sticky flags: a new event in the same cycle as its W1C keeps the bit set.
    cyc_ovf_d = (cyc_ovf_q & ~(wr_status & bus.wdata[ST_CYC_OVF])) | cyc_wrap;
    ins_ovf_d = (ins_ovf_q & ~(wr_status & bus.wdata[ST_INS_OVF])) | ins_wrap;
    cmp_hit_d = (cmp_hit_q & ~(wr_status & bus.wdata[ST_CMP_HIT])) | cmp_set;

    unique case (state_q)
      IDLE: begin
        if (cnt_start) begin
          state_d = RUN;
          en_d    = 1'b1;
        end else if (wr_ctrl && bus.wdata[CTRL_EN]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_ctrl && !bus.wdata[CTRL_EN]) state_d = IDLE;
        else if (frz_q && hlt && !hlt_q)    state_d = HALTED;
      end
      HALTED: begin
        if (wr_ctrl) begin
          if (!bus.wdata[CTRL_EN]) state_d = IDLE;
          else if (!hlt)           state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.rd_en) begin
      rdata_valid_d = 1'b1;
      case (addr_w)
        CTRL_OFF:   rdata_d = {28'b0, irq_en_q, frz_q, 1'b0, en_q};
        STATUS_OFF: rdata_d = {27'b0, cmp_hit_q, ins_ovf_q, cyc_ovf_q,
                               state_q == HALTED, state_q == RUN};
        CYC_LO_OFF: begin
          rdata_d      = cyc_cnt[31:0];
          cyc_shadow_d = cyc_cnt[CNT_W-1:32];
        end
        CYC_HI_OFF: rdata_d = 32'(cyc_shadow_q);
        INS_LO_OFF: begin
          rdata_d      = ins_cnt[31:0];
          ins_shadow_d = ins_cnt[CNT_W-1:32];
        end
        INS_HI_OFF: rdata_d = 32'(ins_shadow_q);
        CMP_OFF:    rdata_d = cmp_q;
        default:    rdata_d = '0;
      endcase
    end

    if (clr) begin
      cyc_shadow_d = '0;
      ins_shadow_d = '0;
    end
  end

  always_ff @(posedge clk or posedge cycle_count_rst) begin
    if (cycle_count_rst) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      frz_q         <= 1'b0;
      irq_en_q      <= 1'b0;
      cyc_ovf_q     <= 1'b0;
      ins_ovf_q     <= 1'b0;
      cmp_hit_q     <= 1'b0;
      hlt_q         <= 1'b0;
      cmp_q         <= '1;
      cyc_shadow_q  <= '0;
      ins_shadow_q  <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      frz_q         <= frz_d;
      irq_en_q      <= irq_en_d;
      cyc_ovf_q     <= cyc_ovf_d;
      ins_ovf_q     <= ins_ovf_d;
      cmp_hit_q     <= cmp_hit_d;
      hlt_q         <= hlt_d;
      cmp_q         <= cmp_d;
      cyc_shadow_q  <= cyc_shadow_d;
      ins_shadow_q  <= ins_shadow_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign irq             = cmp_hit_q & irq_en_q;

endmodule

// File: doc/perf_counter_mmio.md
Name: perf_counter_mmio

Overview:
- Memory-mapped performance-counter peripheral on the CPU data bus.
- Counts clock cycles and retired instructions in hardware, and freezes both on HLT.
- Lets firmware read 64-bit counts atomically, with a cycle-compare interrupt.
- It is the in-design responder for cycle/instruction measurement: software, not the bench, reads and controls the counts.

Parameters:
- CNT_W, 64, width of the cycle and instruction counters (must be 33..64).
- ADDR_W, 3, word-address width of the register window.

Ports:
- clk  input  1  system clock
- cycle_count_rst  input  1  reset, asynchronous, active-high
- cnt_start  input  1  single-cycle pulse; starts counting from IDLE (same as writing CTRL.en=1)
- instr_retire  input  1  one pulse per retired instruction (IF-stage PC advance)
- hlt  input  1  CPU halt level
- addr  input  ADDR_W  word offset into the register window
- wr_en  input  1  write strobe, single cycle
- rd_en  input  1  read strobe, single cycle
- wdata  input  32  write data
- rdata  output  32  read data, registered
- rdata_valid  output  1  high exactly one cycle after rd_en
- irq  output  1  compare interrupt, level, sticky

Behaviour:
- Reset values: all counters 0, CTRL 0, CMP 0xFFFFFFFF, state IDLE, rdata 0, rdata_valid 0, irq 0, shadows 0.
- Register map (word offsets):
  - 0 CTRL: bit0 en, bit1 clr (write-only, self-clearing), bit2 freeze_on_halt, bit3 irq_en.
  - 1 STATUS: bit0 running, bit1 halted, bit2 cyc_ovf, bit3 ins_ovf, bit4 cmp_hit. Bits 2-4 are W1C.
  - 2 CYC_LO: read returns cycle[31:0] and latches cycle[CNT_W-1:32] into cyc_shadow.
  - 3 CYC_HI: returns cyc_shadow, zero-extended.
  - 4 INS_LO: read returns instr[31:0] and latches the instruction high word into ins_shadow.
  - 5 INS_HI: returns ins_shadow, zero-extended.
  - 6 CMP: compare value (read/write).
  - 7: reads 0, writes ignored.
- State machine IDLE / RUN / HALTED:
  - IDLE→RUN on cnt_start or a CTRL write with en=1.
  - RUN→IDLE on a CTRL write with en=0.
  - RUN→HALTED on the hlt rising edge when freeze_on_halt=1. With freeze_on_halt=0, hlt is ignored.
  - HALTED→IDLE on a CTRL write with en=0.
  - HALTED→RUN on a CTRL write with en=1 while hlt=0. If hlt is still 1, stay HALTED.
- Counting:
  - The cycle counter increments every clk in RUN, including the cycle in which the state is entered from the next edge onward.
  - The instruction counter increments on instr_retire in RUN only.
  - Both counters hold in IDLE and HALTED.
- Wrap and overflow: at all-ones the counter wraps to 0 and sets its sticky ovf bit. The ovf bit clears only via W1C or reset.
- clr=1:
  - Zeroes both counters and both shadows next edge.
  - Clear wins over a same-cycle increment.
  - Does not change state or en.
- Compare:
  - In RUN with irq_en=1, when cycle[31:0]==CMP, set cmp_hit; irq = cmp_hit & irq_en.
  - A W1C on cmp_hit in the same cycle as a new match leaves cmp_hit set (set wins).
- Reads:
  - rdata and rdata_valid are updated on the edge after rd_en. Latency 1; back-to-back reads are supported every cycle.
  - Shadow latching happens on the LO read edge. The returned LO value is the counter value before that edge's increment.
- Simultaneous rd_en and wr_en to the same address: the read returns the old value and the write takes effect.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). rdata_valid deasserts with no pending response.
- Unused high bits of rdata read 0.

Decomposition:
- Package perf_params holds:
  - register offset localparams (CTRL_OFF .. CMP_OFF);
  - CTRL/STATUS bit-index constants;
  - typedef enum logic [1:0] {IDLE, RUN, HALTED} perf_state_t.
- Sub-module perf_counter64 (parameter CNT_W; inputs clk, cycle_count_rst, inc, clr; outputs count, wrap_pulse) is instantiated twice, for cycles and instructions.

Test Plan:
- Reset, then cnt_start pulse, wait 100 clk, read CYC_LO → 100±1 with exact value checked against a bench-model count; rdata_valid exactly 1 cycle after rd_en.
- In RUN, 37 instr_retire pulses spread over 80 cycles, then read INS_LO/INS_HI → 37 and 0.
- Force the cycle counter to 0x00000000_FFFFFFFE via hierarchical deposit, run 3 cycles, read CYC_LO then CYC_HI → 0x00000001 and 0x00000001; cyc_ovf stays 0.
- freeze_on_halt=1 in RUN, assert hlt, wait 50 clk, read CYC_LO twice 10 cycles apart → identical values; STATUS = 0x2.
- CMP=20, irq_en=1, start from 0 → irq rises at cycle 20. W1C STATUS bit4 → irq falls next edge. A clr write in the same cycle as instr_retire → INS_LO reads 0.
- Assert cycle_count_rst mid-read (rd_en high) → rdata=0, rdata_valid=0, state IDLE, irq=0 on the next observation.
